// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the multi-channel arbitrated memory.
// Default geometry, request payload layout and pointer sizing helper.
package mem_arb_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned DATA_DEPTH = 64;
    localparam int unsigned CH_COUNT   = 2;
    localparam int unsigned ADDR_W     = $clog2(DATA_DEPTH);
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  wr_rd;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] wr_data;
        logic [BE_WIDTH-1:0]   be;
    } req_t;

    // A single channel still needs a one-bit pointer register.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_mc_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (with wrap) wins,
// and the pointer moves just past the winner.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    localparam int unsigned PW     = ptr_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant_c,
    output logic [PW-1:0]     ptr_next_c
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant_c    = '0;
        ptr_next_c = ptr;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(ptr) + i) % NUM_CH;
            if (!found && req[PW'(idx)]) begin
                found              = 1'b1;
                grant_c[PW'(idx)]  = 1'b1;
                ptr_next_c         = PW'((idx + 1) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/mem_arb_mc.sv
// Single-port byte-writable memory shared by NUM_CH valid/ready requesters,
// round-robin arbitrated, with one-cycle registered read responses.
module mem_arb_mc
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = DATA_WIDTH,
    parameter int unsigned DEPTH      = DATA_DEPTH,
    parameter int unsigned NUM_CH     = CH_COUNT,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            valid_i,
    output logic [NUM_CH-1:0]            ready_o,
    input  logic [NUM_CH-1:0]            wr_rd_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CH*WIDTH-1:0]      wr_data_i,
    input  logic [NUM_CH*(WIDTH/8)-1:0]  be_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [NUM_CH-1:0]            rd_valid_o,
    output logic                         err_o
);

    localparam int unsigned BW = WIDTH / 8;
    localparam int unsigned PW = ptr_width(NUM_CH);

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_next_c;
    logic [NUM_CH-1:0]     grant_c;
    logic                  xfer_c;
    logic                  in_range_c;
    logic                  sel_wr_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [WIDTH-1:0]      sel_data_c;
    logic [BW-1:0]         sel_be_c;
    logic [WIDTH-1:0]      mem [DEPTH];

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req        (valid_i),
        .ptr        (ptr),
        .grant_c    (grant_c),
        .ptr_next_c (ptr_next_c)
    );

    assign ready_o    = rst ? '0 : grant_c;
    assign xfer_c     = |grant_c;
    assign in_range_c = 32'(sel_addr_c) < DEPTH;

    // Payload of the granted channel; grant is one-hot so at most one hit.
    always_comb begin
        sel_wr_c   = 1'b0;
        sel_addr_c = '0;
        sel_data_c = '0;
        sel_be_c   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_c[c]) begin
                sel_wr_c   = wr_rd_i[c];
                sel_addr_c = addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data_c = wr_data_i[c*WIDTH +: WIDTH];
                sel_be_c   = be_i[c*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= '0;
            end
            ptr        <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= '0;
            err_o      <= 1'b0;
        end else begin
            rd_valid_o <= '0;
            err_o      <= 1'b0;
            if (xfer_c) begin
                ptr   <= ptr_next_c;
                err_o <= !in_range_c;
                if (sel_wr_c) begin
                    if (in_range_c) begin
                        for (int unsigned b = 0; b < BW; b++) begin
                            if (sel_be_c[b]) begin
                                mem[sel_addr_c][8*b +: 8] <= sel_data_c[8*b +: 8];
                            end
                        end
                    end
                end else begin
                    rd_valid_o <= grant_c;
                    rd_data_o  <= in_range_c ? mem[sel_addr_c] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_mc.sv
// Directed bench for mem_arb_mc: a DEPTH=64 instance for the main checks and a
// DEPTH=48 instance so that 6-bit addresses can fall out of range.
module tb_mem_arb_mc;
    import mem_arb_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 6;
    localparam int unsigned BW = 2;
    localparam int unsigned NC = 2;

    logic clk = 1'b0;
    logic rst;

    logic [NC-1:0]    valid, wr_rd, ready, rd_valid;
    logic [NC*AW-1:0] addr;
    logic [NC*W-1:0]  wdata;
    logic [NC*BW-1:0] be;
    logic [W-1:0]     rd_data;
    logic             err;

    logic [NC-1:0]    valid48, wr_rd48, ready48, rd_valid48;
    logic [NC*AW-1:0] addr48;
    logic [NC*W-1:0]  wdata48;
    logic [NC*BW-1:0] be48;
    logic [W-1:0]     rd_data48;
    logic             err48;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arb_mc #(.WIDTH(W), .DEPTH(64), .NUM_CH(NC)) u_dut (
        .clk(clk), .rst(rst), .valid_i(valid), .ready_o(ready), .wr_rd_i(wr_rd),
        .addr_i(addr), .wr_data_i(wdata), .be_i(be), .rd_data_o(rd_data),
        .rd_valid_o(rd_valid), .err_o(err)
    );

    mem_arb_mc #(.WIDTH(W), .DEPTH(48), .NUM_CH(NC)) u_dut48 (
        .clk(clk), .rst(rst), .valid_i(valid48), .ready_o(ready48), .wr_rd_i(wr_rd48),
        .addr_i(addr48), .wr_data_i(wdata48), .be_i(be48), .rd_data_o(rd_data48),
        .rd_valid_o(rd_valid48), .err_o(err48)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic wr, input logic [AW-1:0] a,
                                input logic [W-1:0] d, input logic [BW-1:0] b);
        req_t r;
        r.wr_rd   = wr;
        r.addr    = a;
        r.wr_data = d;
        r.be      = b;
        return r;
    endfunction

    task automatic put(input bit d48, input int unsigned ch, input req_t r);
        if (d48) begin
            valid48[ch]              = 1'b1;
            wr_rd48[ch]              = r.wr_rd;
            addr48[ch*AW +: AW]      = r.addr;
            wdata48[ch*W +: W]       = r.wr_data;
            be48[ch*BW +: BW]        = r.be;
        end else begin
            valid[ch]                = 1'b1;
            wr_rd[ch]                = r.wr_rd;
            addr[ch*AW +: AW]        = r.addr;
            wdata[ch*W +: W]         = r.wr_data;
            be[ch*BW +: BW]          = r.be;
        end
    endtask

    task automatic idle();
        valid   = '0;
        valid48 = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        wr_rd = '0; addr = '0; wdata = '0; be = '0;
        wr_rd48 = '0; addr48 = '0; wdata48 = '0; be48 = '0;
        valid = 2'b11;
        valid48 = 2'b11;
        #2;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_ready48", 32'(ready48), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        idle();

        // Cleared memory at both ends of the array
        put(1'b0, 0, mk(1'b0, 6'd0, 16'h0, 2'b00));
        #1 chk("rd0_ready", 32'(ready), 32'h1);
        cyc();
        chk("rd0_valid", 32'(rd_valid), 32'h1);
        chk("rd0_data", 32'(rd_data), 32'h0);
        chk("rd0_err", 32'(err), 32'h0);
        idle();
        put(1'b0, 0, mk(1'b0, 6'd63, 16'h0, 2'b00));
        #1 chk("rd63_ready", 32'(ready), 32'h1);
        cyc();
        chk("rd63_valid", 32'(rd_valid), 32'h1);
        chk("rd63_data", 32'(rd_data), 32'h0);

        // Write then read addr 5 on ch0
        idle();
        put(1'b0, 0, mk(1'b1, 6'd5, 16'hABCD, 2'b11));
        #1 chk("wr5_ready", 32'(ready), 32'h1);
        cyc();
        chk("wr5_no_strobe", 32'(rd_valid), 32'h0);
        idle();
        put(1'b0, 0, mk(1'b0, 6'd5, 16'h0, 2'b00));
        #1 chk("rd5_ready", 32'(ready), 32'h1);
        cyc();
        chk("rd5_valid", 32'(rd_valid), 32'h1);
        chk("rd5_data", 32'(rd_data), 32'hABCD);

        // Byte enables on ch1, including an all-zero enable write
        idle();
        put(1'b0, 1, mk(1'b1, 6'd7, 16'h1234, 2'b11));
        cyc();
        put(1'b0, 1, mk(1'b1, 6'd7, 16'hFF00, 2'b10));
        cyc();
        put(1'b0, 1, mk(1'b1, 6'd7, 16'h0000, 2'b00));
        cyc();
        put(1'b0, 1, mk(1'b0, 6'd7, 16'h0, 2'b00));
        #1 chk("rd7_ready", 32'(ready), 32'h2);
        cyc();
        chk("rd7_valid", 32'(rd_valid), 32'h2);
        chk("rd7_data", 32'(rd_data), 32'hFF34);

        // Contention from ptr=0: grants alternate 01,10,01,10
        idle();
        put(1'b0, 0, mk(1'b0, 6'd5, 16'h0, 2'b00));
        put(1'b0, 1, mk(1'b0, 6'd7, 16'h0, 2'b00));
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", 32'(ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
            chk("rr_strobe", 32'(rd_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_data", 32'(rd_data), (k % 2 == 0) ? 32'hABCD : 32'hFF34);
        end

        // Out-of-range accesses on the DEPTH=48 instance
        idle();
        put(1'b1, 0, mk(1'b1, 6'd2, 16'h7777, 2'b11));
        #1 chk("oor_wr2_ready", 32'(ready48), 32'h1);
        cyc();
        chk("oor_wr2_err", 32'(err48), 32'h0);
        idle();
        put(1'b1, 0, mk(1'b0, 6'd50, 16'h0, 2'b00));
        #1 chk("oor_rd_ready", 32'(ready48), 32'h1);
        cyc();
        chk("oor_rd_valid", 32'(rd_valid48), 32'h1);
        chk("oor_rd_data", 32'(rd_data48), 32'h0);
        chk("oor_rd_err", 32'(err48), 32'h1);
        idle();
        put(1'b1, 1, mk(1'b1, 6'd50, 16'h1111, 2'b11));
        #1 chk("oor_wr_ready", 32'(ready48), 32'h2);
        cyc();
        chk("oor_wr_err", 32'(err48), 32'h1);
        chk("oor_wr_no_strobe", 32'(rd_valid48), 32'h0);
        idle();
        cyc();
        chk("oor_err_pulse_end", 32'(err48), 32'h0);
        put(1'b1, 0, mk(1'b0, 6'd2, 16'h0, 2'b00));
        cyc();
        chk("oor_rd2_data", 32'(rd_data48), 32'h7777);
        chk("oor_rd2_err", 32'(err48), 32'h0);

        // Reset right after a read transfer on ch0 (ptr would otherwise be 1)
        idle();
        put(1'b0, 0, mk(1'b0, 6'd5, 16'h0, 2'b00));
        #1 chk("pre_rst_ready", 32'(ready), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_drop_strobe", 32'(rd_valid), 32'h0);
        chk("rst_mid_data", 32'(rd_data), 32'h0);
        chk("rst_mid_ready", 32'(ready), 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        put(1'b0, 0, mk(1'b0, 6'd5, 16'h0, 2'b00));
        put(1'b0, 1, mk(1'b0, 6'd7, 16'h0, 2'b00));
        #1 chk("post_rst_ptr", 32'(ready), 32'h1);
        cyc();
        chk("post_rst_valid0", 32'(rd_valid), 32'h1);
        chk("post_rst_mem5", 32'(rd_data), 32'h0);
        #1 chk("post_rst_grant1", 32'(ready), 32'h2);
        cyc();
        chk("post_rst_valid1", 32'(rd_valid), 32'h2);
        chk("post_rst_mem7", 32'(rd_data), 32'h0);
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arb_mc.md
# mem_arb_mc

Multi-channel, single-port, byte-writable memory with a round-robin arbiter. It is the next-generation request/response memory in the memory testbench environment. It serves NUM_CH independent valid/ready requesters, accepting one request per cycle and returning read data one cycle after acceptance with a per-channel response strobe. It sits directly under the memory testbench top, behind the per-channel driver interfaces.

## Interface
Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8
- DEPTH, 64, number of words; need not be a power of two
- NUM_CH, 2, number of requester channels, 1..8
- ADDR_WIDTH, $clog2(DEPTH), address width

Ports (channel c occupies slice [c*W +: W] of flattened buses):
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  NUM_CH  request valid per channel
- ready_o  out  NUM_CH  request accepted this cycle (one-hot or zero)
- wr_rd_i  in  NUM_CH  1 = write, 0 = read
- addr_i  in  NUM_CH*ADDR_WIDTH  word address
- wr_data_i  in  NUM_CH*WIDTH  write data
- be_i  in  NUM_CH*(WIDTH/8)  byte enables for writes; ignored on reads
- rd_data_o  out  WIDTH  read data, shared by all channels
- rd_valid_o  out  NUM_CH  one-cycle response strobe for an accepted read
- err_o  out  1  pulses with a response when that access had addr >= DEPTH

## Operation
- Grant: ready_o is a combinational function of valid_i and the priority pointer. The first requesting channel at or after ptr, with wrap-around, is granted. A transfer occurs on a rising edge where valid_i[c] & ready_o[c].
- Priority pointer ptr: resets to 0. After a transfer on channel c, ptr = (c+1) mod NUM_CH. With no transfer, ptr holds.
- Requesters hold valid_i and their payload stable until ready_o is seen. The block never deasserts ready_o for a valid request within the same cycle.
- Write: for each byte b with be_i[b]=1, mem[addr][8b+7:8b] <= wr_data byte b. A write with be_i all zero is accepted and changes nothing. Writes produce no rd_valid_o pulse. An out-of-range write is accepted and discarded, and err_o pulses in the next cycle.
- Read: on transfer, rd_data_o <= mem[addr], rd_valid_o[c] <= 1 for exactly one cycle, and err_o <= 0. Out-of-range read: rd_data_o <= 0, rd_valid_o[c] <= 1, err_o <= 1.
- rd_data_o holds its last value when no read is accepted.
- Reset: all DEPTH entries are cleared to 0. rd_data_o = 0, rd_valid_o = 0, err_o = 0, ptr = 0. ready_o = 0 while rst is high.
- Reset mid-operation: an in-flight response strobe is dropped. Requesters must re-present after reset.

## Timing
- Acceptance: same cycle as valid_i when granted, so zero-wait for an uncontended requester.
- Read latency: exactly 1 cycle from the transfer edge. Data and strobe are registered outputs.
- Throughput: 1 access per cycle aggregate. Each of N continuously requesting channels gets one grant every N cycles.
- Read-after-write to the same address in consecutive cycles returns the new data. Back-to-back reads stream at 1 per cycle.

## Structure
- Package mem_arb_pkg: request struct typedef (wr_rd, addr, wr_data, be) and the localparam BE_WIDTH = WIDTH/8.
- Sub-module rr_arbiter (NUM_CH): takes a request vector and the pointer, and produces a one-hot grant plus the pointer update. The memory array and response registers live in the top.

## Test plan
- Reset with WIDTH=16, DEPTH=64, NUM_CH=2 -> all outputs 0, and reads of addresses 0 and 63 return 0x0000 with rd_valid_o pulsed.
- Ch0 writes 0xABCD to addr 5 with be=11, then reads addr 5 -> ready_o[0] is high both cycles, rd_valid_o=01 one cycle later, and rd_data_o=0xABCD.
- Byte enable: write 0x1234 to addr 7, then 0xFF00 with be=10 -> readback is 0xFF34.
- Contention: both channels hold valid_i for 4 cycles starting at ptr=0 -> grants are 01,10,01,10, and each read strobe lands on the matching channel.
- Out of range: with DEPTH=48, read addr 50 -> rd_data_o=0, err_o=1 with the rd_valid_o pulse. Write to addr 50 -> err_o pulses and no entry changes.
- Assert rst in the cycle after a read transfer -> no rd_valid_o pulse, ptr=0, and memory cleared.
